// File: rtl/axis_dest_mac_tagger_if.sv
// AXI-Stream bundle shared by the input and output sides of the MAC tagger.
// The input side leaves tuser unused; the output side carries the destination tag on it.
interface axis_dest_mac_tagger_if #(
    parameter int DATA_W = 64,
    parameter int ID_W   = 4,
    parameter int USER_W = 4
);
    localparam int KEEP_W = DATA_W / 8;

    logic [DATA_W-1:0] tdata;
    logic [ID_W-1:0]   tid;
    logic [KEEP_W-1:0] tkeep;
    logic              tlast;
    logic [USER_W-1:0] tuser;
    logic              tvalid;
    logic              tready;

    modport master (
        output tdata, tid, tkeep, tlast, tuser, tvalid,
        input  tready
    );

    modport slave (
        input  tdata, tid, tkeep, tlast, tuser, tvalid,
        output tready
    );
endinterface

// File: rtl/axis_dest_mac_tagger.sv
// Per-packet destination tagger: looks up the destination MAC of each header beat
// in a programmable table and drives the matched index on tuser for the whole packet.
module axis_dest_mac_tagger #(
    parameter int AXIS_BUS_WIDTH  = 64,
    parameter int AXIS_ID_WIDTH   = 4,
    parameter int AXIS_DEST_WIDTH = 4,
    parameter int NUM_ENTRIES     = 8,
    parameter int DEFAULT_DEST    = 0,
    localparam int ID_W   = (AXIS_ID_WIDTH > 0) ? AXIS_ID_WIDTH : 1,
    localparam int USER_W = (AXIS_DEST_WIDTH > 0) ? AXIS_DEST_WIDTH : 1,
    localparam int IDX_W  = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1,
    localparam int KEEP_W = AXIS_BUS_WIDTH / 8
) (
    input  logic                          aclk,
    input  logic                          areset,
    axis_dest_mac_tagger_if.slave         axis_in,
    axis_dest_mac_tagger_if.master        axis_out,
    input  logic                          cfg_wr_en,
    input  logic [IDX_W-1:0]              cfg_wr_idx,
    input  logic [47:0]                   cfg_wr_mac,
    input  logic                          cfg_wr_vld,
    output logic [31:0]                   stat_miss_count
);

    typedef enum logic {
        ST_SOP = 1'b0,
        ST_MID = 1'b1
    } state_t;

    state_t                    state_q, state_d;
    logic [47:0]               mac_q [NUM_ENTRIES];
    logic [47:0]               mac_d [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0]    vld_q, vld_d;

    logic [AXIS_BUS_WIDTH-1:0] tdata_q, tdata_d;
    logic [ID_W-1:0]           tid_q, tid_d;
    logic [KEEP_W-1:0]         tkeep_q, tkeep_d;
    logic                      tlast_q, tlast_d;
    logic [USER_W-1:0]         tuser_q, tuser_d;
    logic                      tvalid_q, tvalid_d;
    logic [31:0]               miss_count_q, miss_count_d;

    logic                      in_xfer;
    logic                      hit;
    logic [IDX_W-1:0]          hit_idx;
    logic [USER_W-1:0]         tag;

    assign axis_in.tready = !tvalid_q || axis_out.tready;
    assign in_xfer        = axis_in.tvalid && axis_in.tready;

    // Table lookup on the current beat; the lowest matching index wins.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (vld_q[i] && (mac_q[i] == axis_in.tdata[47:0])) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
        if (axis_in.tkeep[5:0] != 6'h3F) begin
            hit = 1'b0;
        end
        tag = hit ? USER_W'(hit_idx) : USER_W'(DEFAULT_DEST);
    end

    // Table update; lookups this cycle still see the old contents.
    always_comb begin
        mac_d = mac_q;
        vld_d = vld_q;
        if (cfg_wr_en && (32'(cfg_wr_idx) < NUM_ENTRIES)) begin
            mac_d[cfg_wr_idx] = cfg_wr_mac;
            vld_d[cfg_wr_idx] = cfg_wr_vld;
        end
    end

    // Output register, packet state and miss counter next-state.
    always_comb begin
        state_d      = state_q;
        tdata_d      = tdata_q;
        tid_d        = tid_q;
        tkeep_d      = tkeep_q;
        tlast_d      = tlast_q;
        tuser_d      = tuser_q;
        miss_count_d = miss_count_q;
        if (in_xfer) begin
            tdata_d = axis_in.tdata;
            tid_d   = axis_in.tid;
            tkeep_d = axis_in.tkeep;
            tlast_d = axis_in.tlast;
            state_d = axis_in.tlast ? ST_SOP : ST_MID;
            if (state_q == ST_SOP) begin
                tuser_d = tag;
                if (!hit && (miss_count_q != 32'hFFFF_FFFF)) begin
                    miss_count_d = miss_count_q + 32'd1;
                end
            end
        end
        if (in_xfer) begin
            tvalid_d = 1'b1;
        end else if (axis_out.tready) begin
            tvalid_d = 1'b0;
        end else begin
            tvalid_d = tvalid_q;
        end
    end

    // All state registers, cleared asynchronously.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q      <= ST_SOP;
            vld_q        <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                mac_q[i] <= '0;
            end
            tdata_q      <= '0;
            tid_q        <= '0;
            tkeep_q      <= '0;
            tlast_q      <= 1'b0;
            tuser_q      <= '0;
            tvalid_q     <= 1'b0;
            miss_count_q <= '0;
        end else begin
            state_q      <= state_d;
            vld_q        <= vld_d;
            mac_q        <= mac_d;
            tdata_q      <= tdata_d;
            tid_q        <= tid_d;
            tkeep_q      <= tkeep_d;
            tlast_q      <= tlast_d;
            tuser_q      <= tuser_d;
            tvalid_q     <= tvalid_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign axis_out.tdata   = tdata_q;
    assign axis_out.tid     = tid_q;
    assign axis_out.tkeep   = tkeep_q;
    assign axis_out.tlast   = tlast_q;
    assign axis_out.tuser   = tuser_q;
    assign axis_out.tvalid  = tvalid_q;
    assign stat_miss_count  = miss_count_q;

endmodule

// File: tb/tb_axis_dest_mac_tagger.sv
// Self-checking bench for axis_dest_mac_tagger: directed cases plus randomized
// traffic compared against a queue-based reference model of the tagging rules.
module tb_axis_dest_mac_tagger;

    localparam int W    = 64;
    localparam int IDW  = 4;
    localparam int DW   = 4;
    localparam int N    = 8;
    localparam int DEF  = 0;
    localparam int KW   = W / 8;
    localparam int IW   = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    axis_dest_mac_tagger_if #(.DATA_W(W), .ID_W(IDW), .USER_W(DW)) in_if ();
    axis_dest_mac_tagger_if #(.DATA_W(W), .ID_W(IDW), .USER_W(DW)) out_if ();

    logic          cfg_wr_en;
    logic [IW-1:0] cfg_wr_idx;
    logic [47:0]   cfg_wr_mac;
    logic          cfg_wr_vld;
    logic [31:0]   stat;

    axis_dest_mac_tagger #(
        .AXIS_BUS_WIDTH (W),
        .AXIS_ID_WIDTH  (IDW),
        .AXIS_DEST_WIDTH(DW),
        .NUM_ENTRIES    (N),
        .DEFAULT_DEST   (DEF)
    ) dut (
        .aclk           (clk),
        .areset         (rst),
        .axis_in        (in_if),
        .axis_out       (out_if),
        .cfg_wr_en      (cfg_wr_en),
        .cfg_wr_idx     (cfg_wr_idx),
        .cfg_wr_mac     (cfg_wr_mac),
        .cfg_wr_vld     (cfg_wr_vld),
        .stat_miss_count(stat)
    );

    typedef struct packed {
        logic [W-1:0]   d;
        logic [IDW-1:0] id;
        logic [KW-1:0]  k;
        logic           l;
        logic [DW-1:0]  u;
    } beat_t;

    beat_t       exp_q[$];
    logic [47:0] m_mac [N];
    logic        m_vld [N];
    bit          m_hdr;
    logic [DW-1:0] m_tag;
    logic [31:0] m_miss;
    logic [47:0] pool [4];

    int n_chk  = 0;
    int n_fail = 0;
    bit rnd_rdy;
    bit acc;

    task automatic chk(string tag, logic [127:0] got, logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] ref_lookup(input logic [47:0] mac,
                                                 input logic [KW-1:0] k,
                                                 output bit hit);
        logic [DW-1:0] r;
        hit = 1'b0;
        r   = DW'(DEF);
        if (k[5:0] == 6'h3F) begin
            for (int i = 0; i < N; i++) begin
                if (!hit && m_vld[i] && m_mac[i] == mac) begin
                    hit = 1'b1;
                    r   = DW'(i);
                end
            end
        end
        return r;
    endfunction

    task automatic step();
        beat_t b;
        bit    hit;
        out_if.tready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        @(negedge clk);
        chk("in_tready", in_if.tready, (exp_q.size() == 0) || out_if.tready);
        chk("out_tvalid", out_if.tvalid, exp_q.size() != 0);
        chk("miss_count", stat, m_miss);
        if (out_if.tvalid && exp_q.size() != 0) begin
            chk("out_beat", {out_if.tdata, out_if.tid, out_if.tkeep,
                             out_if.tlast, out_if.tuser}, exp_q[0]);
        end
        if (out_if.tvalid && out_if.tready && exp_q.size() != 0) begin
            void'(exp_q.pop_front());
        end
        acc = in_if.tvalid && in_if.tready;
        if (acc) begin
            if (m_hdr) begin
                m_tag = ref_lookup(in_if.tdata[47:0], in_if.tkeep, hit);
                if (!hit && m_miss != 32'hFFFF_FFFF) m_miss++;
            end
            b.d = in_if.tdata;
            b.id = in_if.tid;
            b.k = in_if.tkeep;
            b.l = in_if.tlast;
            b.u = m_tag;
            m_hdr = in_if.tlast;
            exp_q.push_back(b);
        end
        if (cfg_wr_en && int'(cfg_wr_idx) < N) begin
            m_mac[cfg_wr_idx] = cfg_wr_mac;
            m_vld[cfg_wr_idx] = cfg_wr_vld;
        end
        @(posedge clk);
        #1;
        cfg_wr_en = 1'b0;
    endtask

    task automatic idle(int n);
        in_if.tvalid = 1'b0;
        repeat (n) step();
    endtask

    task automatic set_cfg(int idx, logic [47:0] mac, logic v);
        cfg_wr_en  = 1'b1;
        cfg_wr_idx = IW'(idx);
        cfg_wr_mac = mac;
        cfg_wr_vld = v;
    endtask

    task automatic cfg_write(int idx, logic [47:0] mac, logic v);
        set_cfg(idx, mac, v);
        idle(1);
    endtask

    task automatic send_beat(logic [W-1:0] d, logic [KW-1:0] k, logic l);
        int cyc = 0;
        in_if.tvalid = 1'b1;
        in_if.tdata  = d;
        in_if.tkeep  = k;
        in_if.tlast  = l;
        in_if.tid    = IDW'($urandom);
        do begin
            step();
            cyc++;
        end while (!acc && cyc < 200);
        if (!acc) chk("accept_timeout", 0, 1);
        if (!rnd_rdy) chk("throughput", cyc, 1);
        in_if.tvalid = 1'b0;
    endtask

    task automatic send_pkt(logic [47:0] mac, logic [KW-1:0] hk, int len);
        logic [W-1:0] d;
        for (int b = 0; b < len; b++) begin
            d = {$urandom, $urandom};
            if (b == 0) begin
                d[47:0] = mac;
                send_beat(d, hk, len == 1);
            end else begin
                send_beat(d, KW'($urandom) | KW'(1), b == len - 1);
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_if.tvalid = 1'b0;
        cfg_wr_en = 1'b0;
        #1;
        chk("rst_tvalid", out_if.tvalid, 0);
        chk("rst_outputs", {out_if.tdata, out_if.tid, out_if.tkeep,
                            out_if.tlast, out_if.tuser}, 0);
        chk("rst_miss", stat, 0);
        exp_q.delete();
        m_hdr  = 1'b1;
        m_miss = '0;
        m_tag  = '0;
        for (int i = 0; i < N; i++) begin
            m_vld[i] = 1'b0;
            m_mac[i] = '0;
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [47:0] mac;
        logic [KW-1:0] hk;
        in_if.tvalid = 1'b0;
        in_if.tdata  = '0;
        in_if.tid    = '0;
        in_if.tkeep  = '0;
        in_if.tlast  = 1'b0;
        in_if.tuser  = '0;
        out_if.tready = 1'b1;
        cfg_wr_en  = 1'b0;
        cfg_wr_idx = '0;
        cfg_wr_mac = '0;
        cfg_wr_vld = 1'b0;
        rnd_rdy    = 1'b0;
        do_reset();

        // Entry 0 hit on a 3-beat packet
        cfg_write(0, 48'h5544_3322_1100, 1'b1);
        send_pkt(48'h5544_3322_1100, 8'hFF, 3);
        idle(2);
        chk("t1_miss", stat, 0);

        // Empty table: single-beat misses, each new packet is a header
        do_reset();
        send_pkt(48'h1234_5678_9ABC, 8'hFF, 1);
        idle(2);
        chk("t2_miss", stat, 1);
        send_pkt(48'h0000_0000_0000, 8'hFF, 2);
        idle(2);
        chk("t2_miss2", stat, 2);

        // Duplicate MAC in entries 2 and 5; invalidate 2 during a header
        mac = 48'hA1B2_C3D4_E5F6;
        cfg_write(2, mac, 1'b1);
        cfg_write(5, mac, 1'b1);
        send_beat({16'h0, mac}, 8'hFF, 1'b1);
        chk("t3_lowest", out_if.tuser, 2);
        set_cfg(2, mac, 1'b0);
        send_beat({16'h0, mac}, 8'hFF, 1'b1);
        chk("t3_old_tbl", out_if.tuser, 2);
        send_beat({16'h0, mac}, 8'hFF, 1'b1);
        chk("t3_new_tbl", out_if.tuser, 5);
        idle(2);

        // Partial tkeep header is a miss; counter saturation
        cfg_write(0, 48'h0102_0304_0506, 1'b1);
        send_beat({16'h0, 48'h0102_0304_0506}, 8'h0F, 1'b1);
        chk("t5_keep_miss", out_if.tuser, DEF);
        send_pkt(48'h0102_0304_0506, 8'hFF, 2);
        idle(2);
        force dut.miss_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.miss_count_q;
        m_miss = 32'hFFFF_FFFF;
        send_pkt(48'hFFFF_FFFF_FFFF, 8'hFF, 1);
        idle(2);
        chk("t5_saturate", stat, 32'hFFFF_FFFF);

        // Reset mid-packet; the remainder is treated as a header
        do_reset();
        send_beat({$urandom, $urandom}, 8'hFF, 1'b0);
        send_beat({$urandom, $urandom}, 8'hFF, 1'b0);
        do_reset();
        cfg_write(3, 48'h0C0D_0E0F_1011, 1'b1);
        send_beat({16'hBEEF, 48'h0C0D_0E0F_1011}, 8'hFF, 1'b0);
        chk("t6_hdr_tag", out_if.tuser, 3);
        send_beat({$urandom, $urandom}, 8'hFF, 1'b1);
        chk("t6_held_tag", out_if.tuser, 3);
        idle(2);

        // Randomized traffic with backpressure and config churn
        do_reset();
        rnd_rdy = 1'b1;
        for (int i = 0; i < 4; i++) pool[i] = {$urandom, 16'($urandom)};
        for (int i = 0; i < N; i++) begin
            cfg_write(i, pool[$urandom_range(0, 3)], 1'($urandom_range(0, 1)));
        end
        for (int p = 0; p < 1000; p++) begin
            mac = ($urandom_range(0, 9) < 6) ? pool[$urandom_range(0, 3)]
                                             : {$urandom, 16'($urandom)};
            hk  = ($urandom_range(0, 4) != 0) ? 8'hFF : KW'($urandom);
            if ($urandom_range(0, 9) == 0) begin
                set_cfg($urandom_range(0, N - 1), pool[$urandom_range(0, 3)],
                        1'($urandom_range(0, 1)));
            end
            send_pkt(mac, hk, $urandom_range(1, 4));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        rnd_rdy = 1'b0;
        for (int p = 0; p < 50; p++) begin
            send_pkt(pool[$urandom_range(0, 3)], 8'hFF, $urandom_range(1, 4));
        end
        idle(3);
        chk("drain", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
